// File: rtl/machina_pkg.sv
// Shared types and helpers for the training datapath: Q8.8 scalar type,
// 17->16 bit saturation and the objective controller state encoding.
package machina_pkg;

  localparam int unsigned Q_FRAC_W = 8;

  typedef logic signed [15:0] q8_8_t;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_SUB  = 3'd1,
    ST_DEL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_RPT  = 3'd4
  } obj_state_e;

  function automatic q8_8_t sat16(input logic signed [16:0] x);
    if (x > 17'sd32767) begin
      return 16'sh7FFF;
    end else if (x < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return x[15:0];
    end
  endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Unsigned saturating accumulator: load_i adds addend_i, clear_i zeroes
// (clear wins). sum_o is the saturated next value for callers that need it early.
module sat_accumulator #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] addend_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] acc_q;
  logic [W:0]   raw_sum;

  assign raw_sum = {1'b0, acc_q} + {1'b0, addend_i};
  assign sum_o   = raw_sum[W] ? '1 : raw_sum[W-1:0];
  assign acc_o   = acc_q;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/objective.sv
// Terminal objective for one output node: pairs product with target, returns
// the saturated Q8.8 delta while training and reports batch sum of squared error.
module objective
  import machina_pkg::*;
#(
  parameter int unsigned M = 4,
  parameter int unsigned S = Q_FRAC_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        train,
  input  logic        product_valid,
  input  logic [15:0] product_data,
  output logic        product_ready,
  input  logic        target_valid,
  input  logic [15:0] target_data,
  output logic        target_ready,
  output logic        delta_valid,
  output logic [15:0] delta_data,
  input  logic        delta_ready,
  output logic        error_valid,
  output logic [31:0] error_data,
  input  logic        error_ready
);

  localparam int unsigned CNT_W = (M < 2) ? 1 : $clog2(M + 1);

  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both 1; a producer holds valid and data stable until then.

  obj_state_e         state_q;
  q8_8_t              prod_q, tgt_q, delta_q;
  logic               prod_held_q, tgt_held_q;
  logic               delta_valid_q, error_valid_q;
  logic [31:0]        error_data_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [16:0] diff;
  q8_8_t              sat_diff_d;
  logic signed [31:0] delta_ext, sq_full;
  logic [31:0]        sq;
  logic               batch_done, acc_clear, acc_load;
  logic [31:0]        acc_cur, acc_sum;

  assign product_ready = (state_q == ST_LOAD) && !prod_held_q;
  assign target_ready  = (state_q == ST_LOAD) && !tgt_held_q;
  assign delta_valid   = delta_valid_q;
  assign delta_data    = delta_q;
  assign error_valid   = error_valid_q;
  assign error_data    = error_data_q;

  assign diff       = 17'(tgt_q) - 17'(prod_q);
  assign sat_diff_d = sat16(diff);

  // Squaring the registered delta: at most 2^30, so the shifted value is non-negative.
  assign delta_ext = 32'(delta_q);
  assign sq_full   = delta_ext * delta_ext;
  assign sq        = 32'(unsigned'(sq_full) >> S);

  assign cnt_d      = cnt_q + CNT_W'(1);
  assign batch_done = (cnt_d == CNT_W'(M));
  assign acc_clear  = (state_q == ST_ACC) && batch_done;
  assign acc_load   = (state_q == ST_ACC) && !batch_done;

  sat_accumulator #(.W(32)) u_acc (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (acc_clear),
    .load_i   (acc_load),
    .addend_i (sq),
    .acc_o    (acc_cur),
    .sum_o    (acc_sum)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      prod_q        <= '0;
      tgt_q         <= '0;
      prod_held_q   <= 1'b0;
      tgt_held_q    <= 1'b0;
      delta_q       <= '0;
      delta_valid_q <= 1'b0;
      error_valid_q <= 1'b0;
      error_data_q  <= '0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (product_valid && product_ready) begin
            prod_q      <= product_data;
            prod_held_q <= 1'b1;
          end
          if (target_valid && target_ready) begin
            tgt_q      <= target_data;
            tgt_held_q <= 1'b1;
          end
          // Pairing is judged on the registered held flags, so a sample
          // completed at this edge moves on at the following one.
          if (prod_held_q && tgt_held_q) begin
            state_q <= ST_SUB;
          end
        end
        ST_SUB: begin
          delta_q       <= sat_diff_d;
          delta_valid_q <= train;
          state_q       <= train ? ST_DEL : ST_ACC;
        end
        ST_DEL: begin
          if (delta_ready) begin
            delta_valid_q <= 1'b0;
            state_q       <= ST_ACC;
          end
        end
        ST_ACC: begin
          prod_held_q <= 1'b0;
          tgt_held_q  <= 1'b0;
          if (batch_done) begin
            error_data_q  <= acc_sum;
            error_valid_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= ST_RPT;
          end else begin
            cnt_q   <= cnt_d;
            state_q <= ST_LOAD;
          end
        end
        ST_RPT: begin
          if (error_ready) begin
            error_valid_q <= 1'b0;
            state_q       <= ST_LOAD;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (state_q inside {ST_LOAD, ST_SUB, ST_DEL, ST_ACC, ST_RPT})
        else $fatal(1, "objective: illegal state encoding %0d", state_q);
    end
  end

endmodule
